// File: rtl/bpf_cal_seq.sv
// ---------------------------------------------------------------------------
// bpf_cal_seq
//   Multi-channel power-up / calibration / ready sequencer for the band-pass
//   filter banks. Each of N_CH channels runs its own OFF -> CAL -> SETTLE ->
//   READY sequence with an independent down-counter. The per-channel ready
//   flags are combined into ALL_RDY.
//
//   Optional feature: define BPF_CAL_TIMEOUT_EN to add a per-channel
//   calibration watchdog and a FAULT state. Without it CAL_ERR is tied to 0.
//
// Ports
//   CLK      in   1     system clock, rising edge
//   RST_N    in   1     asynchronous active-low reset
//   PU       in   N_CH  per-channel power-up; 0 forces the channel to OFF
//   CAL      in   N_CH  per-channel calibration enable; gates the CAL count
//   RDY      out  N_CH  channel ready, registered
//   BUSY     out  N_CH  channel in CAL or SETTLE, registered
//   ALL_RDY  out  1     all powered channels ready and at least one powered
//   CAL_ERR  out  N_CH  calibration watchdog fault, registered
// ---------------------------------------------------------------------------
module bpf_cal_seq #(
  parameter int N_CH       = 4,
  parameter int CLK_PER_US = 5,
  parameter int T_CAL_US   = 6,
  parameter int T_RDY_US   = 2,
  parameter int TO_US      = 64,
  parameter int CNT_W      = 16
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N_CH-1:0] PU,
  input  logic [N_CH-1:0] CAL,
  output logic [N_CH-1:0] RDY,
  output logic [N_CH-1:0] BUSY,
  output logic            ALL_RDY,
  output logic [N_CH-1:0] CAL_ERR
);

  localparam logic [CNT_W-1:0] T_CAL_CYC = CNT_W'(CLK_PER_US * T_CAL_US);
  localparam logic [CNT_W-1:0] T_RDY_CYC = CNT_W'(CLK_PER_US * T_RDY_US);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Reject configurations the counters cannot represent.
  if (T_CAL_US < 1 || T_RDY_US < 1 ||
      CLK_PER_US * T_CAL_US >= (1 << CNT_W) ||
      CLK_PER_US * T_RDY_US >= (1 << CNT_W) ||
      CLK_PER_US * TO_US    >= (1 << CNT_W)) begin : g_bad_cfg
    $error("bpf_cal_seq: timing parameters out of range for CNT_W");
  end

`ifdef BPF_CAL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_CYC = CNT_W'(CLK_PER_US * TO_US);
`endif

  typedef enum logic [2:0] {
    S_OFF,
    S_CAL,
    S_SETTLE,
    S_READY
`ifdef BPF_CAL_TIMEOUT_EN
    , S_FAULT
`endif
  } state_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           state_q, state_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             rdy_q, busy_q;
`ifdef BPF_CAL_TIMEOUT_EN
    logic [CNT_W-1:0] wd_q, wd_nx;
    logic             err_q;
`endif

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
      state_nx = state_q;
      cnt_nx   = cnt_q;
`ifdef BPF_CAL_TIMEOUT_EN
      wd_nx    = wd_q;
`endif
      if (!PU[i]) begin
        // Power-down wins in every state.
        state_nx = S_OFF;
        cnt_nx   = '0;
`ifdef BPF_CAL_TIMEOUT_EN
        wd_nx    = '0;
`endif
      end else begin
        unique case (state_q)
          S_OFF: begin
            state_nx = S_CAL;
            cnt_nx   = T_CAL_CYC;
`ifdef BPF_CAL_TIMEOUT_EN
            wd_nx    = '0;
`endif
          end
          S_CAL: begin
`ifdef BPF_CAL_TIMEOUT_EN
            wd_nx = wd_q + CNT_ONE;
`endif
            if (CAL[i] && cnt_q == CNT_ONE) begin
              // Finishing calibration takes precedence over a watchdog
              // expiring on the same edge.
              state_nx = S_SETTLE;
              cnt_nx   = T_RDY_CYC;
`ifdef BPF_CAL_TIMEOUT_EN
              wd_nx    = '0;
            end else if (wd_q == TO_CYC) begin
              state_nx = S_FAULT;
              cnt_nx   = '0;
              wd_nx    = '0;
`endif
            end else if (CAL[i]) begin
              cnt_nx = cnt_q - CNT_ONE;
            end
          end
          S_SETTLE: begin
            if (cnt_q == CNT_ONE) begin
              state_nx = S_READY;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt_q - CNT_ONE;
            end
          end
          S_READY: ;  // CAL is ignored; only PU low leaves READY
`ifdef BPF_CAL_TIMEOUT_EN
          S_FAULT: ;  // only PU low or reset leaves FAULT
`endif
          default: begin
            state_nx = S_OFF;
            cnt_nx   = '0;
          end
        endcase
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        state_q <= S_OFF;
        cnt_q   <= '0;
        rdy_q   <= 1'b0;
        busy_q  <= 1'b0;
`ifdef BPF_CAL_TIMEOUT_EN
        wd_q    <= '0;
        err_q   <= 1'b0;
`endif
      end else begin
        state_q <= state_nx;
        cnt_q   <= cnt_nx;
        // Outputs are decoded from the next state so they change on the
        // same edge as the state register.
        rdy_q   <= (state_nx == S_READY);
        busy_q  <= (state_nx == S_CAL) || (state_nx == S_SETTLE);
`ifdef BPF_CAL_TIMEOUT_EN
        wd_q    <= wd_nx;
        err_q   <= (state_nx == S_FAULT);
`endif
      end
    end

    assign RDY[i]  = rdy_q;
    assign BUSY[i] = busy_q;
`ifdef BPF_CAL_TIMEOUT_EN
    assign CAL_ERR[i] = err_q;
`else
    assign CAL_ERR[i] = 1'b0;
`endif
  end

  // Unpowered channels count as ready; at least one channel must be powered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ALL_RDY <= 1'b0;
    end else begin
      ALL_RDY <= (|PU) & (&(RDY | ~PU));
    end
  end

endmodule

// File: tb/tb_bpf_cal_seq.sv
// ---------------------------------------------------------------------------
// tb_bpf_cal_seq
//   Directed bench for bpf_cal_seq with default parameters
//   (T_CAL_CYC = 30, T_RDY_CYC = 10, watchdog limit 320).
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bpf_cal_seq;

  localparam int N_CH = 4;

  logic            CLK;
  logic            RST_N;
  logic [N_CH-1:0] PU;
  logic [N_CH-1:0] CAL;
  logic [N_CH-1:0] RDY;
  logic [N_CH-1:0] BUSY;
  logic            ALL_RDY;
  logic [N_CH-1:0] CAL_ERR;

  int n_cmp = 0;
  int n_err = 0;

  bpf_cal_seq dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .PU      (PU),
    .CAL     (CAL),
    .RDY     (RDY),
    .BUSY    (BUSY),
    .ALL_RDY (ALL_RDY),
    .CAL_ERR (CAL_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, ending on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    RST_N = 1'b0;
    PU    = 4'b1111;
    CAL   = 4'b1111;
    tick(3);
    check("reset_rdy",     32'(RDY),     32'h0);
    check("reset_busy",    32'(BUSY),    32'h0);
    check("reset_all_rdy", 32'(ALL_RDY), 32'h0);
    check("reset_cal_err", 32'(CAL_ERR), 32'h0);

    // 1: ch0 full sequence, CAL held high; entry at the next edge (k).
    PU    = 4'b0001;
    CAL   = 4'b0001;
    RST_N = 1'b1;
    tick(1);
    check("t1_busy_at_k",   32'(BUSY), 32'h1);
    check("t1_rdy_at_k",    32'(RDY),  32'h0);
    tick(39);
    check("t1_busy_k39",    32'(BUSY), 32'h1);
    check("t1_rdy_k39",     32'(RDY),  32'h0);
    tick(1);
    check("t1_rdy_k40",     32'(RDY),  32'h1);
    check("t1_busy_k40",    32'(BUSY), 32'h0);
    check("t1_allrdy_k40",  32'(ALL_RDY), 32'h0);
    tick(1);
    check("t1_allrdy_k41",  32'(ALL_RDY), 32'h1);

    // 2 + 5: ch1 with a 7-cycle CAL dropout; ch0 stays ready.
    PU  = 4'b0011;
    CAL = 4'b0011;
    tick(1);
    check("t2_busy_at_k",   32'(BUSY), 32'h2);
    check("t5_allrdy_partial", 32'(ALL_RDY), 32'h0);
    tick(9);
    CAL = 4'b0001;
    tick(7);
    check("t2_busy_dropout", 32'(BUSY), 32'h2);
    CAL = 4'b0011;
    tick(30);
    check("t2_rdy_k46",     32'(RDY), 32'h1);
    tick(1);
    check("t2_rdy_k47",     32'(RDY), 32'h3);
    check("t5_allrdy_same", 32'(ALL_RDY), 32'h0);
    tick(1);
    check("t5_allrdy_next", 32'(ALL_RDY), 32'h1);

    // 3: ch2, CAL[2] dropped once SETTLE is entered.
    PU  = 4'b0111;
    CAL = 4'b0111;
    tick(31);
    CAL = 4'b0011;
    check("t3_busy_settle", 32'(BUSY), 32'h4);
    tick(9);
    check("t3_rdy_k39",     32'(RDY), 32'h3);
    tick(1);
    check("t3_rdy_k40",     32'(RDY), 32'h7);
    check("t3_busy_k40",    32'(BUSY), 32'h0);

    // 4: ch3 dropped in SETTLE then re-raised.
    PU  = 4'b1111;
    CAL = 4'b1111;
    tick(35);
    check("t4_busy_settle", 32'(BUSY), 32'h8);
    PU = 4'b0111;
    tick(1);
    check("t4_busy_drop",   32'(BUSY), 32'h0);
    check("t4_rdy_drop",    32'(RDY),  32'h7);
    PU = 4'b1111;
    tick(1);
    check("t4_busy_restart", 32'(BUSY), 32'h8);
    tick(39);
    check("t4_rdy_k39",     32'(RDY), 32'h7);
    tick(1);
    check("t4_rdy_k40",     32'(RDY), 32'hF);
    tick(1);
    check("t4_allrdy_all",  32'(ALL_RDY), 32'h1);

    // 4: asynchronous reset mid-CAL.
    PU = 4'b0111;
    tick(1);
    PU = 4'b1111;
    tick(6);
    check("t4_busy_midcal", 32'(BUSY), 32'h8);
    #2 RST_N = 1'b0;
    #1;
    check("t4_async_rdy",     32'(RDY),     32'h0);
    check("t4_async_busy",    32'(BUSY),    32'h0);
    check("t4_async_allrdy",  32'(ALL_RDY), 32'h0);
    check("t4_async_cal_err", 32'(CAL_ERR), 32'h0);
    tick(1);
    RST_N = 1'b1;
    tick(1);
    check("t4_post_rst_busy", 32'(BUSY), 32'hF);
    tick(39);
    check("t4_post_rst_k39",  32'(RDY), 32'h0);
    tick(1);
    check("t4_post_rst_k40",  32'(RDY), 32'hF);
    tick(1);
    check("t4_post_rst_all",  32'(ALL_RDY), 32'h1);

    // 5: nothing powered.
    PU = 4'b0000;
    tick(1);
    check("t5_off_rdy",    32'(RDY),     32'h0);
    check("t5_off_allrdy", 32'(ALL_RDY), 32'h0);

    // 6: ch0 powered with CAL held low.
    PU  = 4'b0001;
    CAL = 4'b0000;
    tick(1);
`ifdef BPF_CAL_TIMEOUT_EN
    tick(320);
    check("t6_wd_busy_k320",   32'(BUSY),    32'h1);
    check("t6_wd_err_k320",    32'(CAL_ERR), 32'h0);
    tick(1);
    check("t6_wd_err_k321",    32'(CAL_ERR), 32'h1);
    check("t6_wd_busy_k321",   32'(BUSY),    32'h0);
    check("t6_wd_rdy_k321",    32'(RDY),     32'h0);
    PU = 4'b0000;
    tick(1);
    check("t6_wd_err_cleared", 32'(CAL_ERR), 32'h0);
`else
    tick(400);
    check("t6_nowd_busy",    32'(BUSY),    32'h1);
    check("t6_nowd_cal_err", 32'(CAL_ERR), 32'h0);
    check("t6_nowd_rdy",     32'(RDY),     32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
